// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Read hits are answered combinationally; misses and stores stall while memory is accessed.
module dcache #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_data_in,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [31:0] cpu_data_out,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        WDONE = 2'd3
    } state_t;

    state_t                  state_r;
    logic [LINES-1:0]        valid_r;
    logic [TAG_W-1:0]        tag_r [LINES];
    logic [31:0]             data_r [LINES][4];
    logic [1:0]              cnt_r;
    logic [31:0]             hit_count_r;
    logic [31:0]             miss_count_r;
    logic                    mem_req_r;
    logic                    mem_rw_r;
    logic [31:0]             mem_addr_r;
    logic [31:0]             mem_wdata_r;

    logic [1:0]              word_s;
    logic [INDEX_BITS-1:0]   index_s;
    logic [TAG_W-1:0]        tag_s;
    logic                    hit_s;
    logic                    unused_ok_s;

    assign word_s      = cpu_addr[3:2];
    assign index_s     = cpu_addr[3+INDEX_BITS:4];
    assign tag_s       = cpu_addr[31:4+INDEX_BITS];
    assign hit_s       = valid_r[index_s] && (tag_r[index_s] == tag_s);
    assign unused_ok_s = &{1'b0, cpu_addr[1:0]};

    assign mem_req    = mem_req_r;
    assign mem_rw     = mem_rw_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;

    // CPU-side stall and hit data; both must respond in the same cycle as the request
    always_comb begin
        cpu_stall    = 1'b0;
        cpu_data_out = 32'h0000_0000;
        if (reset) begin
            cpu_stall    = 1'b0;
            cpu_data_out = 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cpu_write) begin
                        cpu_stall = 1'b1;
                    end else if (cpu_read) begin
                        if (hit_s) begin
                            cpu_data_out = data_r[index_s][word_s];
                        end else begin
                            cpu_stall = 1'b1;
                        end
                    end else begin
                        cpu_stall = 1'b0;
                    end
                end
                FILL:    cpu_stall = 1'b1;
                WRITE:   cpu_stall = 1'b1;
                WDONE:   cpu_stall = 1'b0;
                default: cpu_stall = 1'b0;
            endcase
        end
    end

    // Control FSM: line state, counters and the registered memory request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            valid_r      <= {LINES{1'b0}};
            for (int i = 0; i < LINES; i++) begin
                tag_r[i] <= {TAG_W{1'b0}};
            end
            cnt_r        <= 2'd0;
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
            mem_req_r    <= 1'b0;
            mem_rw_r     <= 1'b1;
            mem_addr_r   <= 32'h0000_0000;
            mem_wdata_r  <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cpu_write) begin
                        state_r     <= WRITE;
                        mem_req_r   <= 1'b1;
                        mem_rw_r    <= 1'b0;
                        mem_addr_r  <= {cpu_addr[31:2], 2'b00};
                        mem_wdata_r <= cpu_data_in;
                    end else if (cpu_read) begin
                        if (hit_s) begin
                            hit_count_r <= hit_count_r + 32'd1;
                        end else begin
                            // Invalidate up front so a half-filled line can never hit
                            miss_count_r     <= miss_count_r + 32'd1;
                            valid_r[index_s] <= 1'b0;
                            cnt_r            <= 2'd0;
                            state_r          <= FILL;
                            mem_req_r        <= 1'b1;
                            mem_rw_r         <= 1'b1;
                            mem_addr_r       <= {cpu_addr[31:4], 4'b0000};
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        cnt_r <= cnt_r + 2'd1;
                        if (cnt_r == 2'd3) begin
                            tag_r[index_s]   <= tag_s;
                            valid_r[index_s] <= 1'b1;
                            state_r          <= IDLE;
                            mem_req_r        <= 1'b0;
                        end else begin
                            mem_addr_r <= {cpu_addr[31:4], cnt_r + 2'd1, 2'b00};
                        end
                    end else begin
                        state_r <= FILL;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        state_r   <= WDONE;
                        mem_req_r <= 1'b0;
                    end else begin
                        state_r <= WRITE;
                    end
                end
                WDONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Line data array: fill words from memory, and keep hit lines coherent on stores
    always_ff @(posedge clk) begin
        if ((state_r == FILL) && mem_ack && !reset) begin
            data_r[index_s][cnt_r] <= mem_rdata;
        end else if ((state_r == WRITE) && mem_ack && hit_s && !reset) begin
            data_r[index_s][word_s] <= cpu_data_in;
        end
    end
endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-through, no-write-allocate data cache between the CPU's memory-stage data port and a multi-cycle word-wide main memory. Read hits return data combinationally with no stall. Misses and all writes stall the pipeline through `cpu_stall` while a small FSM runs req/ack transactions to memory. Lines are 4 words; capacity is set by `INDEX_BITS`.

## Interface
- `INDEX_BITS`, 4, log2 of line count (16 lines × 4 words = 256 B)
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all valid bits, FSM, counters
- `cpu_addr`  in  32  byte address; [1:0] ignored; word = [3:2]; index = [3+INDEX_BITS:4]; tag = [31:4+INDEX_BITS]
- `cpu_data_in`  in  32  store data
- `cpu_read`  in  1  load request, held stable while `cpu_stall`
- `cpu_write`  in  1  store request, held stable while `cpu_stall`
- `cpu_data_out`  out  32  load data, valid when `cpu_read & !cpu_stall`
- `cpu_stall`  out  1  freeze pipeline
- `mem_req`  out  1  memory transaction request
- `mem_rw`  out  1  1 = read, 0 = write (same sense as `read_write` on memories)
- `mem_addr`  out  32  word-aligned memory address
- `mem_wdata`  out  32  write data
- `mem_rdata`  in  32  read data, valid with `mem_ack`
- `mem_ack`  in  1  one-cycle completion pulse; ignored when `mem_req` = 0
- `hit_count`  out  32  completed read hits
- `miss_count`  out  32  read misses started

## Operation
- Storage per line: valid bit, tag, 4 × 32-bit data words. Hit = valid[index] & tag match.
- FSM states: IDLE, FILL, WRITE, WDONE.
- IDLE:
  - `cpu_write`: `cpu_stall`=1; → WRITE. `cpu_write` has priority over `cpu_read` if both are asserted; the read is ignored.
  - `cpu_read` & hit: `cpu_data_out` = line word; `cpu_stall`=0; `hit_count`++.
  - `cpu_read` & miss: `cpu_stall`=1; `miss_count`++; → FILL; fill counter = 0.
  - No request: `cpu_stall`=0.
- FILL:
  - Drives `mem_req`=1, `mem_rw`=1, `mem_addr` = {tag, index, cnt, 2'b00}. Words are fetched 0→3 regardless of the requested word.
  - On `mem_ack`: store `mem_rdata` into word cnt; cnt++.
  - On ack with cnt==3: write tag, set valid, → IDLE. The next cycle re-looks up, hits, and releases the stall. That hit is counted.
  - Line valid is cleared on entry to FILL, so a partially filled line is never reported as a hit.
- WRITE:
  - Drives `mem_req`=1, `mem_rw`=0, `mem_addr` = {cpu_addr[31:2], 2'b00}, `mem_wdata` = `cpu_data_in`.
  - On `mem_ack`: if hit, update the cached word; on a miss the cache is unchanged. → WDONE.
- WDONE: `cpu_stall`=0, `mem_req`=0, one cycle, so the held store is not reissued; → IDLE.
- `cpu_stall` = 1 in FILL and WRITE; in IDLE it follows the rules above; 0 in WDONE.
- `mem_req` is deasserted in IDLE/WDONE. Between acks in FILL it stays high with the updated address.
- Counters wrap modulo 2^32.

## Timing
- Reset (asynchronous, any state):
  - Immediately: state = IDLE, all valid = 0, cnt = 0, counters = 0.
  - Outputs: `mem_req`=0, `cpu_stall`=0, `cpu_data_out`=0.
  - An in-flight memory transaction is abandoned; a late `mem_ack` is ignored.
- Read hit: 0 extra cycles (combinational data, same cycle).
- Read miss: 1 (IDLE) + Σ ack latencies of 4 words + 1 (IDLE re-lookup, stall low). With single-cycle ack: stall high for 5 cycles, data on cycle 6.
- Store: 1 (IDLE) + ack latency in WRITE, then WDONE with stall low. With single-cycle ack: stall high 2 cycles, low in the 3rd.
- Memory inputs are sampled only on `clk` rising edge when `mem_req`=1.

## Test plan
- Reset, then read 0x00000040 with ack every cycle, memory words 0x11,0x22,0x33,0x44 at 0x40–0x4C:
  - `mem_addr` must sequence 0x40, 0x44, 0x48, 0x4C.
  - Stall must stay high 5 cycles, then `cpu_data_out`=0x11.
  - `miss_count`=1, `hit_count`=1.
- Following the above, read 0x48: same-cycle `cpu_data_out`=0x33, `cpu_stall`=0, no `mem_req`.
- Write 0xDEADBEEF to 0x44 (hit), ack after 3 cycles:
  - One memory write with `mem_rw`=0.
  - WDONE cycle with stall low.
  - Subsequent read of 0x44 hits and returns 0xDEADBEEF.
- Write to 0x1040 (same index as 0x40, miss), then read 0x40: the read still hits and returns 0x11 (no allocate).
- Read 0x1040 after the 0x40 fill: conflict miss, refill from 0x1040–0x104C, tag replaced; a subsequent read of 0x40 misses again.
- Assert reset during FILL after 2 acks:
  - `mem_req` drops asynchronously.
  - Line remains invalid.
  - A stray `mem_ack` next cycle has no effect.
  - Re-read performs a full 4-word fill.
